histogram_dump_receiver: RTL and testbench
==========================================

// Module: histogram_dump_receiver
// PURPOSE
//  Consumer end of the histogram dump stream. The histogram accumulator sends one beat per bin,
//  64 consecutive beats, with the 4-bit count in data[3:0] and valid/last framing.
//  This block captures one frame into a local bin store and computes the total and the peak bin.
//  It checks the framing, holds the results until software/host acks, and offers a
//  registered random-access read port.
// PARAMETERS
//  NUM_BINS  64  beats per frame; the index width is 6 bits.
//  BIN_W     4   significant data bits per beat.
//  SUM_W     10  total width; 64*15 = 960 fits, so no saturation is needed.
// PORTS
//  clk           in   1      single clock, rising edge.
//  rst_n         in   1      asynchronous active-low reset.
//  s_valid       in   1      a beat is present on this cycle.
//  s_data        in   8      beat payload; [3:0] is the bin count and [7:4] must be 0.
//  s_last        in   1      marks the final beat (bin 63).
//  ack           in   1      single-cycle pulse; releases the HOLD or ERR state.
//  rd_addr       in   6      bin index for readback.
//  rd_data       out  4      bin_store[rd_addr], registered, 1-cycle latency.
//  busy          out  1      1 in RECV.
//  frame_done    out  1      1-cycle pulse when a good frame completes.
//  results_valid out  1      1 in HOLD.
//  frame_err     out  1      1 in ERR.
//  overrun       out  1      sticky; a beat arrived while in HOLD.
//  total         out  SUM_W  sum of all bins in the frame.
//  peak_idx      out  6      index of the largest bin.
//  peak_val      out  4      value of the largest bin.
//  frame_count   out  8      number of good frames, wraps 255 -> 0.
// BEHAVIOUR
//  Reset: all outputs and state go to 0 / IDLE immediately. bin_store contents are not reset.
//   A reset mid-frame discards the partial frame.
//  FSM IDLE/RECV/HOLD/ERR. A beat is accepted on any cycle with s_valid=1 in IDLE or RECV.
//  IDLE, when s_valid=1:
//   - store beat 0 and set idx=1, total=d, peak_idx=0, peak_val=d, then go to RECV.
//   - if s_last=1 or s_data[7:4]!=0 on this beat, go to ERR instead.
//  RECV: each beat writes bin_store[idx], adds d to total and increments idx.
//   - peak updates only on d > peak_val (strict); a tie keeps the lower index.
//  RECV exits, checked in priority order:
//   1. s_valid=0 (a gap) -> ERR.
//   2. s_data[7:4]!=0 -> ERR.
//   3. s_last=1 with idx<63 (short frame) -> ERR.
//   4. idx=63 with s_last=0 (long frame) -> ERR.
//   5. idx=63 with s_last=1 -> HOLD. frame_done pulses on the next cycle,
//      frame_count increments, and results_valid=1 from the next cycle.
//  HOLD: total/peak/bin_store are frozen.
//   - s_valid=1 beats are dropped and set overrun.
//   - ack returns to IDLE and clears overrun. results_valid drops the next cycle.
//  ERR: frame_err=1; all beats are ignored.
//   - ack is honoured only on a cycle with s_valid=0 (resync); then go to IDLE and clear frame_err.
//   - An ack while s_valid=1 is ignored.
//  ack in IDLE/RECV is ignored.
//  total/peak are meaningful only while results_valid=1; in other states they show running values.
//  Read port: rd_data <= bin_store[rd_addr] every cycle. A read during RECV returns the store
//   contents as of the previous cycle (a same-cycle write is not forwarded).
//  Simultaneous events:
//   - reset dominates everything.
//   - a beat and an ack in the same HOLD cycle: ack wins, the beat is dropped, overrun stays 0.
// TESTING
//  T1: 64 beats d=i%16, last on beat 63 -> frame_done 1 cycle after beat 63; total=480,
//      peak_idx=15, peak_val=15, frame_count=1; rd_addr=17 -> rd_data=1.
//  T2: all-zero frame -> total=0, peak_idx=0, peak_val=0, results_valid=1, frame_err=0.
//  T3: s_last on beat 10 -> frame_err=1, no frame_done, frame_count unchanged.
//  T4: s_valid low at beat 30 -> ERR. ack with s_valid=1 -> stays ERR. ack with s_valid=0 -> IDLE.
//      A following good frame is accepted with total correct.
//  T5: in HOLD, send 3 beats -> overrun=1, total/peak unchanged; ack -> IDLE, overrun=0.
//  T6: rst_n low at beat 20 -> all outputs 0 asynchronously. A fresh full frame afterwards yields
//      frame_count=1 and correct results.

Source files
------------

// File: rtl/histogram_dump_receiver_if.sv
// ============================================================================
// histogram_dump_receiver_if : valid/last beat stream into the dump receiver
// Revision 1.0
// ============================================================================
`default_nettype none

interface histogram_dump_receiver_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last);
  modport slave  (input  s_valid, input  s_data, input  s_last);
endinterface

`default_nettype wire

// File: rtl/histogram_dump_receiver.sv
// ============================================================================
// histogram_dump_receiver : captures a 64-bin frame, reports total and peak
// Revision 1.0
// ============================================================================
`default_nettype none

module histogram_dump_receiver #(
  parameter int NUM_BINS = 64,
  parameter int BIN_W    = 4,
  parameter int SUM_W    = 10,
  localparam int IDX_W   = $clog2(NUM_BINS)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  histogram_dump_receiver_if.slave s_bus,
  input  wire logic              i_ack,
  input  wire logic [IDX_W-1:0]  i_rd_addr,
  output logic      [BIN_W-1:0]  o_rd_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_results_valid,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic      [SUM_W-1:0]  o_total,
  output logic      [IDX_W-1:0]  o_peak_idx,
  output logic      [BIN_W-1:0]  o_peak_val,
  output logic      [7:0]        o_frame_count
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_HOLD, S_ERR} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [SUM_W-1:0]  r_total;
  logic [IDX_W-1:0]  r_peak_idx;
  logic [BIN_W-1:0]  r_peak_val;
  logic [7:0]        r_frame_count;
  logic              r_frame_done;
  logic              r_overrun;
  logic [BIN_W-1:0]  r_rd_data;
  logic [BIN_W-1:0]  r_mem [NUM_BINS];

  logic [BIN_W-1:0]  w_d;
  logic              w_hi_zero;
  logic              w_at_end;
  logic              w_idle_ok;
  logic              w_recv_ok;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [SUM_W-1:0]  w_d_ext;

  assign w_d       = s_bus.s_data[BIN_W-1:0];
  assign w_hi_zero = (s_bus.s_data[7:BIN_W] == '0);
  assign w_at_end  = (r_idx == IDX_W'(NUM_BINS - 1));
  assign w_d_ext   = {{(SUM_W - BIN_W){1'b0}}, w_d};
  assign w_idle_ok = s_bus.s_valid && w_hi_zero && !s_bus.s_last;
  // A beat is good in RECV only when s_last lines up exactly with the final bin.
  assign w_recv_ok = s_bus.s_valid && w_hi_zero && (s_bus.s_last == w_at_end);
  assign w_we      = ((r_state == S_IDLE) && w_idle_ok) || ((r_state == S_RECV) && w_recv_ok);
  assign w_waddr   = (r_state == S_IDLE) ? '0 : r_idx;

  // Bin store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_total       <= '0;
      r_peak_idx    <= '0;
      r_peak_val    <= '0;
      r_frame_count <= '0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_data    <= r_mem[i_rd_addr];
      case (r_state)
        S_IDLE: begin
          if (s_bus.s_valid) begin
            if (w_idle_ok) begin
              r_idx      <= IDX_W'(1);
              r_total    <= w_d_ext;
              r_peak_idx <= '0;
              r_peak_val <= w_d;
              r_state    <= S_RECV;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_RECV: begin
          if (w_recv_ok) begin
            r_total <= r_total + w_d_ext;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_d > r_peak_val) begin
              r_peak_idx <= r_idx;
              r_peak_val <= w_d;
            end
            if (w_at_end) begin
              r_state       <= S_HOLD;
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 8'd1;
            end
          end else begin
            r_state <= S_ERR;
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            r_state   <= S_IDLE;
            r_overrun <= 1'b0;
          end else if (s_bus.s_valid) begin
            r_overrun <= 1'b1;
          end
        end
        S_ERR: begin
          // Ack only resyncs on an idle bus cycle.
          if (i_ack && !s_bus.s_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_data       = r_rd_data;
  assign o_busy          = (r_state == S_RECV);
  assign o_frame_done    = r_frame_done;
  assign o_results_valid = (r_state == S_HOLD);
  assign o_frame_err     = (r_state == S_ERR);
  assign o_overrun       = r_overrun;
  assign o_total         = r_total;
  assign o_peak_idx      = r_peak_idx;
  assign o_peak_val      = r_peak_val;
  assign o_frame_count   = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_histogram_dump_receiver.sv
// ============================================================================
// tb_histogram_dump_receiver : directed frame vectors plus framing corner cases
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_histogram_dump_receiver;

  logic       clk;
  logic       rst_n;
  logic       i_ack;
  logic [5:0] i_rd_addr;
  logic [3:0] o_rd_data;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_results_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic [9:0] o_total;
  logic [5:0] o_peak_idx;
  logic [3:0] o_peak_val;
  logic [7:0] o_frame_count;

  histogram_dump_receiver_if bus ();

  histogram_dump_receiver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_bus           (bus.slave),
    .i_ack           (i_ack),
    .i_rd_addr       (i_rd_addr),
    .o_rd_data       (o_rd_data),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done),
    .o_results_valid (o_results_valid),
    .o_frame_err     (o_frame_err),
    .o_overrun       (o_overrun),
    .o_total         (o_total),
    .o_peak_idx      (o_peak_idx),
    .o_peak_val      (o_peak_val),
    .o_frame_count   (o_frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int rd_addr;
    int exp_total;
    int exp_pidx;
    int exp_pval;
    int exp_rd;
  } vec_t;

  vec_t vecs [5];
  int   n_vec;
  int   n_err;
  int   exp_fc;

  function automatic logic [3:0] beat_d(input int mode, input int i);
    case (mode)
      0:       beat_d = 4'(i % 16);
      1:       beat_d = 4'd0;
      2:       beat_d = (i == 40) ? 4'd9 : 4'd3;
      3:       beat_d = (i == 5 || i == 50) ? 4'd12 : 4'd2;
      default: beat_d = 4'(15 - (i % 16));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
  endtask

  task automatic bus_idle();
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int mode);
    for (int i = 0; i < 64; i++) begin
      drive_beat({4'h0, beat_d(mode, i)}, i == 63);
      tick();
    end
    bus_idle();
  endtask

  task automatic ack_pulse();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_fc = 0;
    vecs[0] = '{0, 17, 480, 15, 15, 1};
    vecs[1] = '{1,  9,   0,  0,  0, 0};
    vecs[2] = '{2, 40, 198, 40,  9, 9};
    vecs[3] = '{3, 50, 148,  5, 12, 12};
    vecs[4] = '{4, 63, 480,  0, 15, 0};

    rst_n = 1'b0; i_ack = 1'b0; i_rd_addr = 6'd0;
    bus_idle();
    repeat (3) tick();
    chk("reset busy", o_busy, 0);
    chk("reset results_valid", o_results_valid, 0);
    chk("reset frame_err", o_frame_err, 0);
    chk("reset total", o_total, 0);
    chk("reset frame_count", o_frame_count, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven good frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].mode);
      exp_fc++;
      chk("frame_done", o_frame_done, 1);
      chk("results_valid", o_results_valid, 1);
      chk("frame_err", o_frame_err, 0);
      chk("busy", o_busy, 0);
      chk("total", o_total, vecs[v].exp_total);
      chk("peak_idx", o_peak_idx, vecs[v].exp_pidx);
      chk("peak_val", o_peak_val, vecs[v].exp_pval);
      chk("frame_count", o_frame_count, exp_fc);
      i_rd_addr = 6'(vecs[v].rd_addr);
      tick();
      chk("rd_data", o_rd_data, vecs[v].exp_rd);
      chk("frame_done pulse ends", o_frame_done, 0);
      chk("results_valid held", o_results_valid, 1);
      ack_pulse();
      chk("results_valid after ack", o_results_valid, 0);
    end

    // Short frame: s_last on beat 10
    for (int i = 0; i <= 10; i++) begin
      drive_beat(8'h03, i == 10);
      tick();
    end
    bus_idle();
    chk("short frame_err", o_frame_err, 1);
    chk("short frame_done", o_frame_done, 0);
    chk("short frame_count", o_frame_count, exp_fc);
    ack_pulse();
    chk("short ack clears err", o_frame_err, 0);

    // Gap at beat 30, then ack with and without s_valid
    for (int i = 0; i < 30; i++) begin
      drive_beat(8'h01, 1'b0);
      tick();
    end
    bus_idle();
    tick();
    chk("gap frame_err", o_frame_err, 1);
    drive_beat(8'h01, 1'b0);
    ack_pulse();
    chk("ack with valid ignored", o_frame_err, 1);
    bus_idle();
    ack_pulse();
    chk("ack resync", o_frame_err, 0);
    chk("resync busy", o_busy, 0);
    send_frame(0);
    exp_fc++;
    chk("post-err total", o_total, 480);
    chk("post-err frame_count", o_frame_count, exp_fc);
    ack_pulse();

    // Bad upper nibble in RECV
    drive_beat(8'h02, 1'b0);
    tick();
    drive_beat(8'h12, 1'b0);
    tick();
    bus_idle();
    chk("upper nibble err", o_frame_err, 1);
    ack_pulse();

    // Overrun in HOLD
    send_frame(0);
    exp_fc++;
    for (int i = 0; i < 3; i++) begin
      drive_beat(8'h0F, 1'b0);
      tick();
    end
    bus_idle();
    chk("overrun set", o_overrun, 1);
    chk("overrun total frozen", o_total, 480);
    chk("overrun peak_idx frozen", o_peak_idx, 15);
    chk("overrun results_valid", o_results_valid, 1);
    i_rd_addr = 6'd3;
    tick();
    chk("overrun store frozen", o_rd_data, 3);
    ack_pulse();
    chk("overrun cleared", o_overrun, 0);
    chk("ack to idle", o_results_valid, 0);

    // Beat and ack in the same HOLD cycle
    send_frame(1);
    exp_fc++;
    drive_beat(8'h05, 1'b0);
    ack_pulse();
    bus_idle();
    chk("simul ack overrun", o_overrun, 0);
    chk("simul ack results_valid", o_results_valid, 0);
    chk("simul ack busy", o_busy, 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 20; i++) begin
      drive_beat({4'h0, beat_d(0, i)}, 1'b0);
      tick();
    end
    chk("pre-reset busy", o_busy, 1);
    chk("pre-reset total", o_total, 126);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", o_busy, 0);
    chk("async reset total", o_total, 0);
    chk("async reset frame_count", o_frame_count, 0);
    chk("async reset peak_val", o_peak_val, 0);
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    exp_fc = 0;
    send_frame(0);
    exp_fc++;
    chk("post-reset frame_count", o_frame_count, exp_fc);
    chk("post-reset total", o_total, 480);
    chk("post-reset peak_idx", o_peak_idx, 15);
    i_rd_addr = 6'd17;
    tick();
    chk("post-reset rd_data", o_rd_data, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
